// File: rtl/amber_wb_resp_pkg.sv
// Shared types for the Amber Wishbone responder: bus widths, FSM states,
// the latched request record and the address window helper.
package amber_wb_resp_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 128;
  localparam int WB_SEL_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_resp_state_t;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

  // span is one bit wider than the address so a full 4 GiB window still fits
  function automatic logic adr_in_window(input logic [WB_ADR_W-1:0] adr,
                                         input logic [WB_ADR_W-1:0] base,
                                         input logic [WB_ADR_W:0]   span);
    logic [WB_ADR_W-1:0] off;
    off = adr - base;
    return {1'b0, off} < span;
  endfunction

endpackage

// File: rtl/amber_wb_resp_mem.sv
// Byte-enabled line RAM for the responder. Bus lanes override the preload
// port when both hit the same line in one cycle; reads are combinational.
module amber_wb_resp_mem
  import amber_wb_resp_pkg::*;
#(
  parameter  int LINES = 256,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                bus_we,
  input  logic [IDX_W-1:0]    bus_idx,
  input  logic [WB_SEL_W-1:0] bus_sel,
  input  logic [WB_DAT_W-1:0] bus_dat,
  input  logic                load_en,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic [WB_DAT_W-1:0] load_dat,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [WB_DAT_W-1:0] rd_dat
);

  logic [WB_DAT_W-1:0] mem [LINES];

  // later non-blocking writes win, so bus lanes land on top of a same-line load
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_dat;
    if (bus_we) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (bus_sel[b]) mem[bus_idx][8*b +: 8] <= bus_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone B3 classic slave for the Amber 128-bit master with programmable
// wait states. Define AMBER_WB_RESP_ERR_EN to answer out-of-window accesses with err.
module amber_wb_responder
  import amber_wb_resp_pkg::*;
#(
  parameter  int                  MEM_LINES = 256,
  parameter  logic [WB_ADR_W-1:0] BASE_ADR  = 32'h0000_0000,
  parameter  int                  DEF_WAIT  = 0,
  localparam int                  IDX_W     = $clog2(MEM_LINES)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WB_ADR_W-1:0] i_wb_adr,
  input  logic [WB_SEL_W-1:0] i_wb_sel,
  input  logic                i_wb_we,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  input  logic                i_wait_ovr,
  input  logic [3:0]          i_wait,
  input  logic                i_load_en,
  input  logic [IDX_W-1:0]    i_load_idx,
  input  logic [WB_DAT_W-1:0] i_load_dat,
  output logic                o_busy
);

  wb_resp_state_t      state;
  wb_req_t             req;
  logic [3:0]          cnt;
  logic [3:0]          eff_wait;
  logic [WB_ADR_W-1:0] req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [WB_DAT_W-1:0] rd_dat;
  logic                new_oor;
  logic                req_oor;
  logic                unused_off;

  assign eff_wait   = i_wait_ovr ? i_wait : 4'(DEF_WAIT);
  assign req_off    = req.adr - BASE_ADR;
  assign req_idx    = req_off[4 +: IDX_W];
  assign unused_off = ^req_off;

`ifdef AMBER_WB_RESP_ERR_EN
  localparam int                SPAN_W = WB_ADR_W + 1;
  localparam logic [WB_ADR_W:0] SPAN   = SPAN_W'(MEM_LINES) << 4;
  assign new_oor = !adr_in_window(i_wb_adr, BASE_ADR, SPAN);
  assign req_oor = !adr_in_window(req.adr, BASE_ADR, SPAN);
`else
  assign new_oor = 1'b0;
  assign req_oor = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      req      <= '0;
      cnt      <= '0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            req <= '{adr: i_wb_adr, sel: i_wb_sel, we: i_wb_we, dat: i_wb_dat};
            cnt <= eff_wait;
            if (eff_wait == 4'd0) begin
              state    <= RESP;
              o_wb_ack <= !new_oor;
              o_wb_err <= new_oor;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state    <= RESP;
              o_wb_ack <= !req_oor;
              o_wb_err <= req_oor;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state != IDLE);
  assign o_wb_dat = (state == RESP && !req.we && o_wb_ack) ? rd_dat : '0;

  amber_wb_resp_mem #(.LINES(MEM_LINES)) u_mem (
    .clk      (i_clk),
    .bus_we   (state == RESP && req.we && o_wb_ack),
    .bus_idx  (req_idx),
    .bus_sel  (req.sel),
    .bus_dat  (req.dat),
    .load_en  (i_load_en),
    .load_idx (i_load_idx),
    .load_dat (i_load_dat),
    .rd_idx   (req_idx),
    .rd_dat   (rd_dat)
  );

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder: latency, lane writes, abort,
// reset mid-access, load/bus collision and out-of-window handling.
module tb_amber_wb_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  wb_adr = '0;
  logic [15:0]  wb_sel = '0;
  logic         wb_we = 1'b0;
  logic [127:0] wb_dat_w = '0;
  logic         wb_cyc = 1'b0;
  logic         wb_stb = 1'b0;
  logic [127:0] wb_dat_r;
  logic         wb_ack;
  logic         wb_err;
  logic         wait_ovr = 1'b0;
  logic [3:0]   wait_val = '0;
  logic         load_en = 1'b0;
  logic [7:0]   load_idx = '0;
  logic [127:0] load_dat = '0;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic         coll_en = 1'b0;
  logic [7:0]   coll_idx = '0;
  logic [127:0] coll_dat = '0;

  localparam logic [127:0] L0 = 128'hF0081003_F0081003_F0081003_E3A00001;
  localparam logic [127:0] L1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] L3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] L5 = 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5;

  always #5 clk = ~clk;

  amber_wb_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wb_adr   (wb_adr),
    .i_wb_sel   (wb_sel),
    .i_wb_we    (wb_we),
    .i_wb_dat   (wb_dat_w),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .o_wb_dat   (wb_dat_r),
    .o_wb_ack   (wb_ack),
    .o_wb_err   (wb_err),
    .i_wait_ovr (wait_ovr),
    .i_wait     (wait_val),
    .i_load_en  (load_en),
    .i_load_idx (load_idx),
    .i_load_dat (load_dat),
    .o_busy     (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_line(input logic [7:0] idx, input logic [127:0] dat);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_dat = dat;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // lat counts negedges after the sampling posedge until ack/err is seen
  task automatic access(input logic [31:0] adr, input logic [15:0] sel, input logic we,
                        input logic [127:0] dat, input logic [3:0] mid_wait,
                        output logic [127:0] rdat, output int lat, output int busy_n,
                        output logic got_err, output logic stray);
    @(posedge clk); #1;
    wb_adr = adr; wb_sel = sel; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wait_val = mid_wait;
    lat = 0; busy_n = 0; got_err = 1'b0; stray = 1'b0; rdat = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (wb_ack && wb_err) stray = 1'b1;
      if (wb_ack || wb_err) begin
        lat = n; rdat = wb_dat_r; got_err = wb_err;
        if (coll_en) begin
          load_en = 1'b1; load_idx = coll_idx; load_dat = coll_dat;
        end
        break;
      end else if (wb_dat_r != '0) begin
        stray = 1'b1;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    load_en = 1'b0; coll_en = 1'b0;
    if (wb_ack || wb_err || busy || wb_dat_r != '0) stray = 1'b1;
    if (lat == 0) chk("timeout", 128'(lat), 128'd1);
  endtask

  logic [127:0] rd;
  int           lat, bn;
  logic         er, st;

  initial begin
    #23;
    chk("rst_ack", 128'(wb_ack), 128'd0);
    chk("rst_err", 128'(wb_err), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dat", wb_dat_r, 128'd0);
    @(negedge clk); rst_n = 1'b1;

    load_line(8'd0, L0);
    load_line(8'd1, L1);
    load_line(8'd2, {128{1'b1}});
    load_line(8'd3, L3);
    load_line(8'd5, L5);
    load_line(8'd6, 128'd0);

    // zero-wait read of line 0
    access(32'h0, 16'hFFFF, 1'b0, '0, 4'd0, rd, lat, bn, er, st);
    chk("w0_lat", 128'(lat), 128'd1);
    chk("w0_dat", rd, L0);
    chk("w0_busy", 128'(bn), 128'd1);
    chk("w0_stray", 128'(st), 128'd0);

    // wait=3, and i_wait changed mid-access must not matter
    wait_ovr = 1'b1; wait_val = 4'd3;
    access(32'h10, 16'hFFFF, 1'b0, '0, 4'd9, rd, lat, bn, er, st);
    chk("w3_lat", 128'(lat), 128'd4);
    chk("w3_busy", 128'(bn), 128'd4);
    chk("w3_dat", rd, L1);
    chk("w3_stray", 128'(st), 128'd0);

    // partial lane write into an all-ones line
    wait_ovr = 1'b0;
    access(32'h20, 16'h000F, 1'b1, '0, 4'd0, rd, lat, bn, er, st);
    chk("wr_lat", 128'(lat), 128'd1);
    chk("wr_rdat", rd, 128'd0);
    access(32'h20, 16'hFFFF, 1'b0, '0, 4'd0, rd, lat, bn, er, st);
    chk("wr_back", rd, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});

    // abort: cyc drops during wait=5 write
    wait_ovr = 1'b1; wait_val = 4'd5;
    @(posedge clk); #1;
    wb_adr = 32'h30; wb_sel = 16'hFFFF; wb_we = 1'b1; wb_dat_w = '0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("ab_ack1", 128'(wb_ack), 128'd0);
    @(negedge clk); chk("ab_ack2", 128'(wb_ack), 128'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("ab_busy", 128'(busy), 128'd0);
    chk("ab_ack3", 128'(wb_ack), 128'd0);
    access(32'h30, 16'hFFFF, 1'b0, '0, 4'd5, rd, lat, bn, er, st);
    chk("ab_lat", 128'(lat), 128'd6);
    chk("ab_mem", rd, L3);

    // out-of-window address
    wait_ovr = 1'b0;
    access(32'h1000, 16'hFFFF, 1'b0, '0, 4'd0, rd, lat, bn, er, st);
    chk("oor_lat", 128'(lat), 128'd1);
`ifdef AMBER_WB_RESP_ERR_EN
    chk("oor_err", 128'(er), 128'd1);
    chk("oor_dat", rd, 128'd0);
`else
    chk("oor_err", 128'(er), 128'd0);
    chk("oor_dat", rd, L0);
`endif
    chk("oor_stray", 128'(st), 128'd0);

    // reset during WAIT of a write to line 5
    wait_ovr = 1'b1; wait_val = 4'd4;
    @(posedge clk); #1;
    wb_adr = 32'h50; wb_sel = 16'hFFFF; wb_we = 1'b1; wb_dat_w = '0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    chk("rs_busy_pre", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_busy", 128'(busy), 128'd0);
    chk("rs_ack", 128'(wb_ack), 128'd0);
    chk("rs_dat", wb_dat_r, 128'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    access(32'h50, 16'hFFFF, 1'b0, '0, 4'd4, rd, lat, bn, er, st);
    chk("rs_lat", 128'(lat), 128'd5);
    chk("rs_mem", rd, L5);

    // sel=0 write acks but leaves memory alone
    wait_ovr = 1'b0;
    access(32'h10, 16'h0000, 1'b1, '0, 4'd0, rd, lat, bn, er, st);
    chk("s0_lat", 128'(lat), 128'd1);
    access(32'h10, 16'hFFFF, 1'b0, '0, 4'd0, rd, lat, bn, er, st);
    chk("s0_mem", rd, L1);

    // load and bus write to line 6 completing in the same cycle
    coll_en = 1'b1; coll_idx = 8'd6; coll_dat = {4{32'h55555555}};
    access(32'h60, 16'h00FF, 1'b1, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 4'd0,
           rd, lat, bn, er, st);
    access(32'h60, 16'hFFFF, 1'b0, '0, 4'd0, rd, lat, bn, er, st);
    chk("coll_mem", rd, {64'h55555555_55555555, 64'hFEDCBA98_76543210});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
